jtag_scan_master: RTL and testbench

- Bit-level JTAG master that generates TCK/TMS/TDI for the TAP_and_UUL boundary-scan target from simple command requests, and captures TDO.
- Replaces hand-written TMS/TDI stimulus: a host FSM or test logic issues "TAP reset", "IR scan" or "DR scan" with length and data.
- Runs on the board clock and divides it down to TCK. Every scan starts and ends in Run-Test/Idle.

---
 rtl/jtag_scan_master_if.sv | 28 ++
 rtl/jtag_scan_master.sv | 169 ++++++++++++++++
 tb/tb_jtag_scan_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_scan_master_if.sv
// Command/status and JTAG pin bundle for jtag_scan_master.
// The master modport is the scan engine's view; slave is the host/target side.
interface jtag_scan_master_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
);
  logic               start;
  logic [1:0]         cmd;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] tdi_data;
  logic [MAX_LEN-1:0] tdo_data;
  logic               busy;
  logic               done;
  logic               TCK;
  logic               TMS;
  logic               TDI;
  logic               TDO;

  modport master (
    input  start, cmd, len, tdi_data, TDO,
    output tdo_data, busy, done, TCK, TMS, TDI
  );

  modport slave (
    output start, cmd, len, tdi_data, TDO,
    input  tdo_data, busy, done, TCK, TMS, TDI
  );
endinterface

// File: rtl/jtag_scan_master.sv
// Bit-level JTAG master: TAP reset, IR scan and DR scan sequences from the board clock.
// Every sequence starts and ends in Run-Test/Idle; TDO is captured on each shift pulse.
module jtag_scan_master #(
  parameter int TCK_HALF = 5,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5
) (
  input logic              clk_50MHz,
  input logic              rst_n,
  jtag_scan_master_if.master bus
);

  localparam int              PH_W    = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(TCK_HALF - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {RST_SEQ, IDLE, HDR, SHIFT, TAIL} state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [2:0]         pulse_q, pulse_d;
  logic [LEN_W-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] tdi_q, tdi_d;
  logic [MAX_LEN-1:0] tdo_q, tdo_d;
  logic               is_ir_q, is_ir_d;
  logic               auto_q, auto_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_bit_q, tdi_bit_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_eff;

  // {TMS, TDI} for the pulse identified by state and counters.
  function automatic logic [1:0] pins(state_t s, logic [2:0] p, logic [LEN_W-1:0] b,
                                      logic ir, logic [LEN_W-1:0] l,
                                      logic [MAX_LEN-1:0] d);
    logic [MAX_LEN-1:0] sh;
    sh = d >> b;
    case (s)
      RST_SEQ: return {p != 3'd5, 1'b0};
      HDR:     return {ir ? (p < 3'd2) : (p == 3'd0), 1'b0};
      SHIFT:   return {b == l - LEN_W'(1), sh[0]};
      TAIL:    return {p == 3'd0, 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    pulse_d   = pulse_q;
    bit_d     = bit_q;
    len_d     = len_q;
    tdi_d     = tdi_q;
    tdo_d     = tdo_q;
    is_ir_d   = is_ir_q;
    auto_d    = auto_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_bit_d = tdi_bit_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    len_eff   = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

    case (state_q)
      IDLE: begin
        tck_d   = 1'b0;
        ph_d    = '0;
        pulse_d = '0;
        bit_d   = '0;
        if (auto_q) begin
          state_d = RST_SEQ;
          auto_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (bus.start && bus.cmd == 2'b00) begin
          state_d = RST_SEQ;
          busy_d  = 1'b1;
        end else if (bus.start && (bus.cmd == 2'b01 || bus.cmd == 2'b10) && bus.len != '0) begin
          state_d = HDR;
          busy_d  = 1'b1;
          is_ir_d = (bus.cmd == 2'b01);
          len_d   = len_eff;
          tdi_d   = bus.tdi_data;
          tdo_d   = '0;
        end
        {tms_d, tdi_bit_d} = pins(state_d, '0, '0, is_ir_d, len_d, tdi_d);
      end
      default: begin
        if (ph_q != PH_LAST) begin
          ph_d = ph_q + PH_W'(1);
        end else begin
          ph_d = '0;
          if (!tck_q) begin
            tck_d = 1'b1;
            if (state_q == SHIFT)
              tdo_d = tdo_q | (MAX_LEN'(bus.TDO) << bit_q);
          end else begin
            // End of a pulse: advance counters, then drive pins for the next low phase.
            tck_d = 1'b0;
            case (state_q)
              RST_SEQ: if (pulse_q == 3'd5) state_d = IDLE;
                       else pulse_d = pulse_q + 3'd1;
              HDR: if (pulse_q == (is_ir_q ? 3'd3 : 3'd2)) begin
                     state_d = SHIFT;
                     bit_d   = '0;
                   end else pulse_d = pulse_q + 3'd1;
              SHIFT: if (bit_q == len_q - LEN_W'(1)) begin
                       state_d = TAIL;
                       pulse_d = '0;
                     end else bit_d = bit_q + LEN_W'(1);
              TAIL: if (pulse_q == 3'd1) state_d = IDLE;
                    else pulse_d = pulse_q + 3'd1;
              default: state_d = IDLE;
            endcase
            if (state_d == IDLE) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end
            {tms_d, tdi_bit_d} = pins(state_d, pulse_d, bit_d, is_ir_q, len_q, tdi_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      pulse_q   <= '0;
      bit_q     <= '0;
      len_q     <= '0;
      tdi_q     <= '0;
      tdo_q     <= '0;
      is_ir_q   <= 1'b0;
      auto_q    <= 1'b1;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_bit_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      pulse_q   <= pulse_d;
      bit_q     <= bit_d;
      len_q     <= len_d;
      tdi_q     <= tdi_d;
      tdo_q     <= tdo_d;
      is_ir_q   <= is_ir_d;
      auto_q    <= auto_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_bit_q <= tdi_bit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.TCK      = tck_q;
  assign bus.TMS      = tms_q;
  assign bus.TDI      = tdi_bit_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tdo_data = tdo_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Self-checking bench for jtag_scan_master: a behavioural TAP target follows TCK/TMS,
// supplies TDO and records traces that are compared with sequences built from the JTAG rules.
module tb_jtag_scan_master;
  localparam int TH = 2;
  localparam int ML = 16;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtag_scan_master_if #(.MAX_LEN(ML), .LEN_W(LW)) bus ();

  jtag_scan_master #(.TCK_HALF(TH), .MAX_LEN(ML), .LEN_W(LW)) dut (
    .clk_50MHz(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Standard 16-state TAP controller of the target.
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUSEDR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPIR} tap_t;

  function automatic tap_t tap_next(tap_t s, logic tms);
    case (s)
      TLR:     return tms ? TLR   : RTI;
      RTI:     return tms ? SELDR : RTI;
      SELDR:   return tms ? SELIR : CAPDR;
      CAPDR:   return tms ? EX1DR : SHDR;
      SHDR:    return tms ? EX1DR : SHDR;
      EX1DR:   return tms ? UPDR  : PAUSEDR;
      PAUSEDR: return tms ? EX2DR : PAUSEDR;
      EX2DR:   return tms ? UPDR  : SHDR;
      UPDR:    return tms ? SELDR : RTI;
      SELIR:   return tms ? TLR   : CAPIR;
      CAPIR:   return tms ? EX1IR : SHIR;
      SHIR:    return tms ? EX1IR : SHIR;
      EX1IR:   return tms ? UPIR  : PAUSEIR;
      PAUSEIR: return tms ? EX2IR : PAUSEIR;
      EX2IR:   return tms ? UPIR  : SHIR;
      default: return tms ? SELDR : RTI;
    endcase
  endfunction

  tap_t        tap = TLR;
  logic        tck_prev = 1'b0;
  logic        tdo_drv = 1'b0;
  logic [15:0] tdo_pat = '0;
  logic [31:0] obs_tms, obs_tdi, obs_shift;
  int          obs_n, shift_n;
  logic [15:0] model_tdo = '0;

  assign bus.TDO = tdo_drv;

  always @(negedge clk) begin
    if (bus.TCK && !tck_prev) begin
      obs_tms |= 32'(bus.TMS) << obs_n;
      obs_tdi |= 32'(bus.TDI) << obs_n;
      obs_n++;
      if (tap == SHDR || tap == SHIR) begin
        obs_shift |= 32'(bus.TDI) << shift_n;
        shift_n++;
      end
      tap = tap_next(tap, bus.TMS);
    end else if (!bus.TCK && tck_prev) begin
      tdo_drv = ((tap == SHDR || tap == SHIR) && shift_n < 16) ? tdo_pat[shift_n[3:0]] : 1'b0;
    end
    tck_prev = bus.TCK;
  end

  task automatic clear_obs();
    obs_tms = '0; obs_tdi = '0; obs_shift = '0; obs_n = 0; shift_n = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tck"},  32'(bus.TCK),      32'd0);
    check({tag, "_tms"},  32'(bus.TMS),      32'd1);
    check({tag, "_tdi"},  32'(bus.TDI),      32'd0);
    check({tag, "_busy"}, 32'(bus.busy),     32'd0);
    check({tag, "_done"}, 32'(bus.done),     32'd0);
    check({tag, "_tdo"},  32'(bus.tdo_data), 32'd0);
  endtask

  // issue=0 observes the automatic TAP reset that follows rst_n release.
  task automatic do_seq(input string name, input bit issue, input logic [1:0] c,
                        input logic [4:0] l, input logic [15:0] d, input logic [15:0] p,
                        input bit poke, input bit chk_tab, input int tab_pulses,
                        input logic [15:0] tab_tdo);
    bit          valid, scan, seen, fin;
    int          L, e_n, hn, busy_cyc, done_cnt;
    logic [31:0] e_tms, e_tdi, mask;
    logic [15:0] e_tdo;

    scan  = issue && (c == 2'b01 || c == 2'b10) && l != 0;
    valid = !issue || c == 2'b00 || scan;
    L     = (int'(l) > 16) ? 16 : int'(l);
    mask  = (32'd1 << L) - 32'd1;
    e_tms = '0; e_tdi = '0; e_n = 0;
    e_tdo = model_tdo;
    if (valid && !scan) begin
      for (int i = 0; i < 6; i++) begin e_tms[e_n] = (i < 5); e_n++; end
    end else if (scan) begin
      hn = (c == 2'b01) ? 4 : 3;
      for (int i = 0; i < hn; i++) begin e_tms[e_n] = (i < hn - 2); e_n++; end
      for (int k = 0; k < L; k++) begin
        e_tms[e_n] = (k == L - 1);
        e_tdi[e_n] = d[k];
        e_n++;
      end
      e_tms[e_n] = 1'b1; e_n++;
      e_n++;
      e_tdo = p & mask[15:0];
    end
    model_tdo = e_tdo;

    clear_obs();
    tdo_pat = p;
    if (issue) begin
      bus.start = 1'b1; bus.cmd = c; bus.len = l; bus.tdi_data = d;
    end
    busy_cyc = 0; done_cnt = 0; seen = 0; fin = 0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) bus.start = 1'b0;
      if (poke && cyc == 3) begin
        bus.start = 1'b1; bus.cmd = 2'b01; bus.len = 5'd5; bus.tdi_data = 16'($urandom);
      end
      if (poke && cyc == 4) begin bus.start = 1'b0; bus.cmd = 2'b00; end
      if (bus.busy) begin busy_cyc++; seen = 1; end
      if (bus.done) begin
        done_cnt++;
        check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      end
      if ((seen && !bus.busy) || (!valid && cyc >= 30)) fin = 1;
    end
    check({name, "_finished"}, 32'(fin), 32'd1);
    check({name, "_pulses"}, 32'(obs_n), 32'(e_n));
    check({name, "_busy_cycles"}, 32'(busy_cyc), 32'(e_n * 2 * TH));
    check({name, "_done_count"}, 32'(done_cnt), valid ? 32'd1 : 32'd0);
    check({name, "_tms_trace"}, obs_tms, e_tms);
    check({name, "_tdi_trace"}, obs_tdi, e_tdi);
    check({name, "_tdo_data"}, 32'(bus.tdo_data), 32'(e_tdo));
    if (valid) check({name, "_tap_rti"}, 32'(tap), 32'(RTI));
    if (scan) begin
      check({name, "_shift_count"}, 32'(shift_n), 32'(L));
      check({name, "_shifted_in"}, obs_shift, 32'(d) & mask);
    end
    if (chk_tab) begin
      check({name, "_tab_pulses"}, 32'(obs_n), 32'(tab_pulses));
      check({name, "_tab_tdo"}, 32'(bus.tdo_data), 32'(tab_tdo));
    end
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  c;
    logic [4:0]  l;
    logic [15:0] d;
    logic [15:0] p;
    bit          poke;
    int          pulses;
    logic [15:0] tdo;
  } vec_t;

  vec_t tab [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          to;
    logic [1:0]  rc;
    logic [4:0]  rl;
    int          r;

    tab[0] = '{c: 2'b01, l: 5'd3,  d: 16'h0002, p: 16'h0000, poke: 0, pulses: 9,  tdo: 16'h0000};
    tab[1] = '{c: 2'b10, l: 5'd10, d: 16'h0120, p: 16'h0000, poke: 1, pulses: 15, tdo: 16'h0000};
    tab[2] = '{c: 2'b10, l: 5'd8,  d: 16'h003C, p: 16'h00A5, poke: 0, pulses: 13, tdo: 16'h00A5};
    tab[3] = '{c: 2'b10, l: 5'd20, d: 16'hBEEF, p: 16'h1234, poke: 0, pulses: 21, tdo: 16'h1234};
    tab[4] = '{c: 2'b01, l: 5'd16, d: 16'h8001, p: 16'hFFFF, poke: 0, pulses: 22, tdo: 16'hFFFF};
    tab[5] = '{c: 2'b00, l: 5'd0,  d: 16'h0000, p: 16'h0000, poke: 0, pulses: 6,  tdo: 16'hFFFF};
    tab[6] = '{c: 2'b11, l: 5'd4,  d: 16'h000F, p: 16'h0000, poke: 0, pulses: 0,  tdo: 16'hFFFF};
    tab[7] = '{c: 2'b10, l: 5'd0,  d: 16'h000F, p: 16'h0000, poke: 0, pulses: 0,  tdo: 16'hFFFF};
    tab[8] = '{c: 2'b10, l: 5'd1,  d: 16'h0001, p: 16'h0001, poke: 0, pulses: 6,  tdo: 16'h0001};

    bus.start = 1'b0; bus.cmd = 2'b00; bus.len = '0; bus.tdi_data = '0;
    clear_obs();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    do_seq("auto_rst", 0, 2'b00, 5'd0, 16'h0, 16'h0, 0, 1, 6, 16'h0000);

    for (int i = 0; i < 9; i++)
      do_seq($sformatf("vec%0d", i), 1, tab[i].c, tab[i].l, tab[i].d, tab[i].p,
             tab[i].poke, 1, tab[i].pulses, tab[i].tdo);

    // Reset asserted in the middle of a DR shift.
    clear_obs();
    tdo_pat = 16'h005A;
    bus.start = 1'b1; bus.cmd = 2'b10; bus.len = 5'd8; bus.tdi_data = 16'h00C3;
    @(negedge clk);
    bus.start = 1'b0;
    to = 1;
    for (int cyc = 0; cyc < 300 && to; cyc++) begin
      @(negedge clk);
      if (shift_n >= 4) to = 0;
    end
    check("mid_rst_reach_shift", 32'(to), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (3) @(negedge clk);
    clear_obs();
    model_tdo = '0;
    rst_n = 1'b1;
    do_seq("post_rst_auto", 0, 2'b00, 5'd0, 16'h0, 16'h0, 0, 1, 6, 16'h0000);
    do_seq("post_rst_dr", 1, 2'b10, 5'd8, 16'h00C3, 16'h005A, 0, 1, 13, 16'h005A);

    for (int n = 0; n < 25; n++) begin
      r  = $urandom_range(0, 9);
      rc = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r < 6) ? 2'b01 : 2'b10;
      r  = $urandom_range(0, 9);
      rl = (r == 0) ? 5'd0 : (r == 1) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(1, 16));
      do_seq($sformatf("rnd%0d", n), 1, rc, rl, 16'($urandom), 16'($urandom),
             ($urandom_range(0, 3) == 0), 0, 0, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
